// File: rtl/dct_pkg.sv
// Shared constants for the forward integer DCT line stage: mode codes, basis
// tables, accumulator sizing and the round/saturate helper.
package dct_pkg;

  localparam logic [1:0] MODE_4PT = 2'b00;
  localparam logic [1:0] MODE_8PT = 2'b01;

  // Guard bits over the input width; the largest 8-point row gain fits in 11.
  localparam int ACC_GUARD = 11;

  typedef enum logic {COL_COLLECT, COL_PENDING} col_st_e;
  typedef enum logic {OUT_IDLE, OUT_SEND} out_st_e;

  localparam int C8 [8][8] = '{
    '{64,  64,  64,  64,  64,  64,  64,  64},
    '{89,  75,  50,  18, -18, -50, -75, -89},
    '{83,  36, -36, -83, -83, -36,  36,  83},
    '{75, -18, -89, -50,  50,  89,  18, -75},
    '{64, -64, -64,  64,  64, -64, -64,  64},
    '{50, -89,  18,  75, -75, -18,  89, -50},
    '{36, -83,  83, -36, -36,  83, -83,  36},
    '{18, -50,  75, -89,  89, -75,  50, -18}
  };

  localparam int C4 [4][4] = '{
    '{64,  64,  64,  64},
    '{83,  36, -36, -83},
    '{64, -64, -64,  64},
    '{36, -83,  83, -36}
  };

  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    r  = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/dct_kernel.sv
// Combinational N-point forward DCT: eight samples in, eight rounded and
// saturated coefficients out (upper four are zero in 4-point mode).
module dct_kernel
  import dct_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT4 = 1,
  parameter int SHIFT8 = 2
) (
  input  logic signed [IN_W-1:0]  x_i [8],
  input  logic                    n8_i,
  output logic signed [OUT_W-1:0] y_o [8]
);

  localparam int ACC_W = IN_W + ACC_GUARD;

  always_comb begin
    logic signed [ACC_W-1:0] acc;
    for (int k = 0; k < 8; k++) begin
      acc = '0;
      for (int n = 0; n < 8; n++) begin
        if (n8_i) begin
          acc = acc + ACC_W'(C8[k][n]) * ACC_W'(x_i[n]);
        end else if (k < 4 && n < 4) begin
          acc = acc + ACC_W'(C4[k][n]) * ACC_W'(x_i[n]);
        end
      end
      y_o[k] = OUT_W'(round_sat(64'(acc), n8_i ? SHIFT8 : SHIFT4, OUT_W));
    end
  end

endmodule

// File: rtl/dct_line.sv
// Forward DCT line stage: collects one row of residuals serially, transforms it
// in a single registered step, and streams the coefficients out DC first.
module dct_line
  import dct_pkg::*;
#(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT4 = 1,
  parameter int SHIFT8 = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_last
);

  col_st_e col_st_q, col_st_d;
  out_st_e out_st_q, out_st_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic       n8_q, n8_d;
  logic       rsv_q, rsv_d;
  logic       on8_q;
  logic signed [IN_W-1:0]  buf_q  [8];
  logic signed [OUT_W-1:0] coef_q [8];

  logic signed [IN_W-1:0]  kx [8];
  logic signed [OUT_W-1:0] ky [8];
  logic accept, first, n8_row, row_done, idx_last, hs_last, xfer;

  always_comb begin
    first    = (cnt_q == 3'd0);
    n8_row   = first ? (mode != MODE_4PT) : n8_q;
    idx_last = (idx_q == (on8_q ? 3'd7 : 3'd3));
    hs_last  = (out_st_q == OUT_SEND) && out_ready && idx_last;
    // A pending row can move on the same edge the previous row's last
    // coefficient leaves, so the collect side never stalls at full rate.
    xfer     = (col_st_q == COL_PENDING) && ((out_st_q == OUT_IDLE) || hs_last);
    in_ready = !rst && ((col_st_q == COL_COLLECT) || xfer);
    accept   = in_valid && in_ready;
    row_done = accept && (cnt_q == (n8_row ? 3'd7 : 3'd3));
  end

  always_comb begin
    col_st_d = col_st_q;
    cnt_d    = cnt_q;
    n8_d     = n8_q;
    rsv_d    = rsv_q;
    if (xfer) col_st_d = COL_COLLECT;
    if (accept) begin
      cnt_d = row_done ? 3'd0 : cnt_q + 3'd1;
      if (first) begin
        n8_d  = (mode != MODE_4PT);
        rsv_d = mode[1];
      end
      if (row_done) col_st_d = COL_PENDING;
    end
  end

  always_comb begin
    out_st_d = out_st_q;
    idx_d    = idx_q;
    case (out_st_q)
      OUT_IDLE: begin
        if (xfer) begin
          out_st_d = OUT_SEND;
          idx_d    = 3'd0;
        end
      end
      OUT_SEND: begin
        if (out_ready) begin
          if (idx_last) begin
            idx_d    = 3'd0;
            out_st_d = xfer ? OUT_SEND : OUT_IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: out_st_d = OUT_IDLE;
    endcase
  end

  // Reserved modes transform an all-zero row.
  always_comb begin
    for (int n = 0; n < 8; n++) kx[n] = rsv_q ? '0 : buf_q[n];
  end

  dct_kernel #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT4(SHIFT4),
    .SHIFT8(SHIFT8)
  ) u_kernel (
    .x_i (kx),
    .n8_i(n8_q),
    .y_o (ky)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      col_st_q <= COL_COLLECT;
      out_st_q <= OUT_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      n8_q     <= 1'b0;
      rsv_q    <= 1'b0;
      on8_q    <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        buf_q[n]  <= '0;
        coef_q[n] <= '0;
      end
    end else begin
      col_st_q <= col_st_d;
      out_st_q <= out_st_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      n8_q     <= n8_d;
      rsv_q    <= rsv_d;
      if (accept) buf_q[cnt_q] <= in_data;
      if (xfer) begin
        on8_q <= n8_q;
        for (int n = 0; n < 8; n++) coef_q[n] <= ky[n];
      end
    end
  end

  always_comb begin
    out_valid = (out_st_q == OUT_SEND);
    out_data  = out_valid ? coef_q[idx_q] : '0;
    out_last  = out_valid && idx_last;
  end

endmodule
